// File: rtl/boot_loader_pkg.sv
// +-----------------------------------------------------------------------+
// | Module   : boot_loader_pkg                                            |
// | Brief    : Shared constants for the byte-stream boot loader: reset    |
// |            levels, byte/word widths, hold default, state encodings.   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

package boot_loader_pkg;

   localparam logic RstEnable  = 1'b1;
   localparam logic RstDisable = 1'b0;

   localparam int c_BYTE_W       = 8;
   localparam int c_WORD_W       = 32;
   localparam int c_LEN_W        = 16;
   localparam int c_RST_HOLD_DEF = 4;

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_LEN_HI = 3'd1;
   localparam logic [2:0] c_ST_LEN_LO = 3'd2;
   localparam logic [2:0] c_ST_DATA   = 3'd3;
   localparam logic [2:0] c_ST_CSUM   = 3'd4;
   localparam logic [2:0] c_ST_RUN    = 3'd5;
   localparam logic [2:0] c_ST_ERR    = 3'd6;

   // States in which the loader consumes bytes from the stream.
   function automatic logic accepts_bytes(input logic [2:0] st);
      return (st == c_ST_LEN_HI) || (st == c_ST_LEN_LO) ||
             (st == c_ST_DATA)   || (st == c_ST_CSUM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/boot_word_pack.sv
// +-----------------------------------------------------------------------+
// | Module   : boot_word_pack                                             |
// | Brief    : Packs four bytes MSB-first into a word and issues a        |
// |            one-cycle write strobe the cycle after the 4th byte.       |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module boot_word_pack
   import boot_loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                shift_en,
   input  logic [c_BYTE_W-1:0] byte_in,
   output logic                word_done,
   output logic                we,
   output logic [c_WORD_W-1:0] wdata
);

   logic [1:0]                     r_cnt;
   logic [c_WORD_W-c_BYTE_W-1:0]   r_shift;

   assign word_done = shift_en && (r_cnt == 2'd3);

   // wdata is a separate register so it stays stable between strobes.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_cnt   <= 2'd0;
         r_shift <= '0;
         we      <= 1'b0;
         wdata   <= '0;
      end else begin
         we <= word_done;
         if (shift_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[c_WORD_W-2*c_BYTE_W-1:0], byte_in};
         end
         if (word_done) begin
            wdata <= {r_shift, byte_in};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// +-----------------------------------------------------------------------+
// | Module   : boot_loader                                                |
// | Brief    : Receives a length-prefixed program image over a byte       |
// |            stream, writes it into instruction ROM and releases the    |
// |            CPU reset. Define BOOT_CHECKSUM_EN to require a trailing   |
// |            XOR checksum byte.                                         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module boot_loader
   import boot_loader_pkg::*;
#(
   parameter int ADDR_W   = 17,
   parameter int RST_HOLD = c_RST_HOLD_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [c_BYTE_W-1:0] in_data,
   output logic                in_ready,
   input  logic                boot_req,
   output logic                rom_we,
   output logic [ADDR_W-1:0]   rom_addr,
   output logic [c_WORD_W-1:0] rom_wdata,
   output logic                cpu_rst,
   output logic                done,
   output logic                error
);

`ifdef BOOT_CHECKSUM_EN
   localparam logic [2:0] c_ST_TAIL = c_ST_CSUM;
`else
   localparam logic [2:0] c_ST_TAIL = c_ST_RUN;
`endif

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [c_LEN_W-1:0] r_len;
   logic [c_LEN_W-1:0] w_len_new;
   logic [c_LEN_W-1:0] r_word_cnt;
   logic [15:0]        r_hold;
   logic               w_xfer;
   logic               w_word_done;
   logic               w_last_word;
   logic               w_oversize;
   logic               w_restart;
   logic               w_enter_data;
   logic               w_released;

   assign in_ready     = accepts_bytes(r_state);
   assign w_xfer       = in_valid && in_ready;
   assign w_len_new    = {r_len[c_LEN_W-1:c_BYTE_W], in_data};
   assign w_last_word  = (r_word_cnt == r_len - 16'd1);
   assign w_restart    = boot_req && ((r_state == c_ST_RUN) || (r_state == c_ST_ERR));
   assign w_enter_data = (r_state == c_ST_LEN_LO) && (w_state_nxt == c_ST_DATA);
   assign w_released   = (r_state == c_ST_RUN) && (r_hold == 16'd0);

   assign cpu_rst = !w_released;
   assign done    = w_released;
   assign error   = (r_state == c_ST_ERR);

   // A 16-bit length can only exceed the ROM when the ROM is smaller than 2^16 words.
   generate
      if (ADDR_W < c_LEN_W) begin : g_oversize
         assign w_oversize = (17'(w_len_new) > (17'd1 << ADDR_W));
      end else begin : g_no_oversize
         assign w_oversize = 1'b0;
      end
   endgenerate

   boot_word_pack u_pack (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (w_xfer && (r_state == c_ST_DATA)),
      .byte_in   (in_data),
      .word_done (w_word_done),
      .we        (rom_we),
      .wdata     (rom_wdata)
   );

`ifdef BOOT_CHECKSUM_EN
   logic [c_BYTE_W-1:0] r_csum;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_csum <= '0;
      end else if ((r_state == c_ST_IDLE) || w_restart) begin
         r_csum <= '0;
      end else if (w_xfer && (r_state != c_ST_CSUM)) begin
         r_csum <= r_csum ^ in_data;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:   w_state_nxt = c_ST_LEN_HI;
         c_ST_LEN_HI: if (w_xfer) w_state_nxt = c_ST_LEN_LO;
         c_ST_LEN_LO: begin
            if (w_xfer) begin
               if (w_len_new == '0)  w_state_nxt = c_ST_TAIL;
               else if (w_oversize)  w_state_nxt = c_ST_ERR;
               else                  w_state_nxt = c_ST_DATA;
            end
         end
         c_ST_DATA:   if (w_word_done && w_last_word) w_state_nxt = c_ST_TAIL;
`ifdef BOOT_CHECKSUM_EN
         c_ST_CSUM: begin
            if (w_xfer) w_state_nxt = (in_data == r_csum) ? c_ST_RUN : c_ST_ERR;
         end
`endif
         c_ST_RUN, c_ST_ERR: if (w_restart) w_state_nxt = c_ST_LEN_HI;
         default:     w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_state    <= c_ST_IDLE;
         r_len      <= '0;
         r_word_cnt <= '0;
         r_hold     <= '0;
         rom_addr   <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_xfer && (r_state == c_ST_LEN_HI)) r_len[c_LEN_W-1:c_BYTE_W] <= in_data;
         if (w_xfer && (r_state == c_ST_LEN_LO)) r_len[c_BYTE_W-1:0]       <= in_data;

         if (w_enter_data)     r_word_cnt <= '0;
         else if (w_word_done) r_word_cnt <= r_word_cnt + 16'd1;

         // Address advances the cycle after each strobe.
         if (w_enter_data) rom_addr <= '0;
         else if (rom_we)  rom_addr <= rom_addr + 1'b1;

         if ((r_state != c_ST_RUN) && (w_state_nxt == c_ST_RUN)) begin
            r_hold <= 16'(RST_HOLD);
         end else if ((r_state == c_ST_RUN) && (r_hold != 16'd0)) begin
            r_hold <= r_hold - 16'd1;
         end
      end
   end

endmodule

`default_nettype wire
